vex_ctrl_pipe: RTL and testbench

Parametrised control/sideband pipeline for the vector execution stage. It carries destination register, ticket, head/end-of-uop flags and valid bits through a configurable number of EX stages plus a writeback slot. Unlike the fixed 4-stage free-running pipe it replaces, it supports backpressure from writeback, flush, and per-stage advance enables for the lane datapaths (`vex_pipe`). It also reports occupancy and idle status, and drives both forwarding taps at parameter-selected stages.

---
 rtl/vex_ctrl_pipe_pkg.sv | 20 ++
 rtl/vex_ctrl_slot.sv | 33 +++
 rtl/vex_ctrl_pipe.sv | 136 +++++++++++++
 tb/tb_vex_ctrl_pipe.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vex_ctrl_pipe_pkg.sv
// rtl/vex_ctrl_pipe_pkg.sv - shared types and helpers for the vector execution control pipe
package vex_ctrl_pipe_pkg;

  localparam int VEX_REGS        = 32;
  localparam int VEX_RW          = $clog2(VEX_REGS);
  localparam int VEX_TICKET_BITS = 5;

  typedef struct packed {
    logic [VEX_RW-1:0]          dst;
    logic [VEX_TICKET_BITS-1:0] ticket;
    logic                       head;
    logic                       last;
  } vex_sideband_t;

  // Flattened slot payload width: {dst, ticket, head, end}
  function automatic int sb_width(input int rw, input int tb);
    return rw + tb + 2;
  endfunction

endpackage

// File: rtl/vex_ctrl_slot.sv
// rtl/vex_ctrl_slot.sv - one control-pipe slot: valid bit plus load-enabled sideband payload
module vex_ctrl_slot #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         adv,
  input  logic         pred_vld,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic         vld,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
    end else if (flush) begin
      vld <= 1'b0;
    end else if (adv) begin
      vld <= pred_vld;
    end
  end

  // Payload is deliberately unreset; only the valid bit qualifies it.
  always_ff @(posedge clk) begin
    if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/vex_ctrl_pipe.sv
// rtl/vex_ctrl_pipe.sv - parametrised EX/WR control pipe with backpressure, flush and forwarding taps
module vex_ctrl_pipe
  import vex_ctrl_pipe_pkg::*;
#(
  parameter int NUM_EX             = 4,
  parameter int VECTOR_REGISTERS   = 32,
  parameter int VECTOR_TICKET_BITS = 5,
  parameter int FWD_POINT_A        = 1,
  parameter int FWD_POINT_B        = 3,
  localparam int RW                = $clog2(VECTOR_REGISTERS),
  localparam int CW                = $clog2(NUM_EX + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          valid_i,
  input  logic [RW-1:0]                 dst_i,
  input  logic [VECTOR_TICKET_BITS-1:0] ticket_i,
  input  logic                          head_i,
  input  logic                          end_i,
  output logic                          ready_o,
  input  logic                          flush_i,
  output logic [NUM_EX-1:0]             stage_en_o,
  output logic [NUM_EX-1:0]             stage_vld_o,
  output logic                          frw_a_en_o,
  output logic [RW-1:0]                 frw_a_addr_o,
  output logic [VECTOR_TICKET_BITS-1:0] frw_a_ticket_o,
  output logic                          frw_b_en_o,
  output logic [RW-1:0]                 frw_b_addr_o,
  output logic [VECTOR_TICKET_BITS-1:0] frw_b_ticket_o,
  output logic                          wr_valid_o,
  input  logic                          wr_ready_i,
  output logic [RW-1:0]                 wr_addr_o,
  output logic [VECTOR_TICKET_BITS-1:0] wr_ticket_o,
  output logic                          wr_head_o,
  output logic                          wr_end_o,
  output logic                          rdc_done_o,
  output logic [CW-1:0]                 inflight_o,
  output logic                          vex_idle_o
);

  localparam int SW = sb_width(RW, VECTOR_TICKET_BITS);
  localparam int TB = VECTOR_TICKET_BITS;

  if (NUM_EX < 2) begin : g_bad_num_ex
    $error("vex_ctrl_pipe: NUM_EX must be >= 2");
  end
  if (FWD_POINT_A < 1 || FWD_POINT_A > NUM_EX) begin : g_bad_fwd_a
    $error("vex_ctrl_pipe: FWD_POINT_A out of range 1..NUM_EX");
  end
  if (FWD_POINT_B < 1 || FWD_POINT_B > NUM_EX) begin : g_bad_fwd_b
    $error("vex_ctrl_pipe: FWD_POINT_B out of range 1..NUM_EX");
  end

  // Index i is slot EX(i+2); index NUM_EX-1 is WR.
  logic [NUM_EX-1:0] vld;
  logic [NUM_EX-1:0] adv;
  logic [NUM_EX-1:0] pred_vld;
  logic [SW-1:0]     sb [NUM_EX];
  logic [SW-1:0]     sb_in;
  logic              accept;
  logic              wr_hs;

  // Advance ripples from WR back to EX2 so bubbles collapse within one cycle.
  always_comb begin
    logic a;
    a = ~vld[NUM_EX-1] | wr_ready_i;
    adv[NUM_EX-1] = a;
    for (int i = NUM_EX - 2; i >= 0; i--) begin
      a = ~vld[i] | a;
      adv[i] = a;
    end
  end

  assign pred_vld   = {vld[NUM_EX-2:0], valid_i};
  assign stage_en_o = adv & pred_vld & {NUM_EX{~flush_i}};
  assign ready_o    = adv[0] & ~flush_i;
  assign accept     = valid_i & ready_o;
  assign sb_in      = {dst_i, ticket_i, head_i, end_i};

  for (genvar i = 0; i < NUM_EX; i++) begin : g_slot
    vex_ctrl_slot #(.W(SW)) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush_i),
      .adv      (adv[i]),
      .pred_vld (pred_vld[i]),
      .load     (stage_en_o[i]),
      .d        ((i == 0) ? sb_in : sb[(i == 0) ? 0 : i - 1]),
      .vld      (vld[i]),
      .q        (sb[i])
    );
  end

  assign stage_vld_o = vld;
  assign wr_valid_o  = vld[NUM_EX-1];
  assign wr_addr_o   = sb[NUM_EX-1][SW-1 -: RW];
  assign wr_ticket_o = sb[NUM_EX-1][TB+1:2];
  assign wr_head_o   = sb[NUM_EX-1][1];
  assign wr_end_o    = sb[NUM_EX-1][0];
  assign wr_hs       = wr_valid_o & wr_ready_i;
  assign rdc_done_o  = wr_hs & wr_end_o;

  if (FWD_POINT_A == 1) begin : g_tap_a_in
    assign frw_a_en_o     = accept;
    assign frw_a_addr_o   = dst_i;
    assign frw_a_ticket_o = ticket_i;
  end else begin : g_tap_a_slot
    assign frw_a_en_o     = vld[FWD_POINT_A-2];
    assign frw_a_addr_o   = sb[FWD_POINT_A-2][SW-1 -: RW];
    assign frw_a_ticket_o = sb[FWD_POINT_A-2][TB+1:2];
  end

  if (FWD_POINT_B == 1) begin : g_tap_b_in
    assign frw_b_en_o     = accept;
    assign frw_b_addr_o   = dst_i;
    assign frw_b_ticket_o = ticket_i;
  end else begin : g_tap_b_slot
    assign frw_b_en_o     = vld[FWD_POINT_B-2];
    assign frw_b_addr_o   = sb[FWD_POINT_B-2][SW-1 -: RW];
    assign frw_b_ticket_o = sb[FWD_POINT_B-2][TB+1:2];
  end

  // Kept incrementally rather than as a popcount so the output is a clean register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_o <= '0;
    end else if (flush_i) begin
      inflight_o <= '0;
    end else begin
      inflight_o <= inflight_o + CW'(accept) - CW'(wr_hs);
    end
  end

  assign vex_idle_o = ~valid_i & (inflight_o == '0);

endmodule

// File: tb/tb_vex_ctrl_pipe.sv
// tb/tb_vex_ctrl_pipe.sv - scoreboard bench for vex_ctrl_pipe with directed vectors
module tb_vex_ctrl_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_i, head_i, end_i, flush_i, wr_ready_i;
  logic [4:0] dst_i, ticket_i;
  logic       ready_o;
  logic [3:0] stage_en_o, stage_vld_o;
  logic       frw_a_en_o, frw_b_en_o;
  logic [4:0] frw_a_addr_o, frw_a_ticket_o, frw_b_addr_o, frw_b_ticket_o;
  logic       wr_valid_o, wr_head_o, wr_end_o, rdc_done_o, vex_idle_o;
  logic [4:0] wr_addr_o, wr_ticket_o;
  logic [2:0] inflight_o;

  vex_ctrl_pipe dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .dst_i(dst_i), .ticket_i(ticket_i),
    .head_i(head_i), .end_i(end_i), .ready_o(ready_o), .flush_i(flush_i),
    .stage_en_o(stage_en_o), .stage_vld_o(stage_vld_o),
    .frw_a_en_o(frw_a_en_o), .frw_a_addr_o(frw_a_addr_o), .frw_a_ticket_o(frw_a_ticket_o),
    .frw_b_en_o(frw_b_en_o), .frw_b_addr_o(frw_b_addr_o), .frw_b_ticket_o(frw_b_ticket_o),
    .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i), .wr_addr_o(wr_addr_o),
    .wr_ticket_o(wr_ticket_o), .wr_head_o(wr_head_o), .wr_end_o(wr_end_o),
    .rdc_done_o(rdc_done_o), .inflight_o(inflight_o), .vex_idle_o(vex_idle_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] dst;
    logic [4:0] tk;
    logic       h;
    logic       e;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rdc_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] d, input logic [4:0] t,
                       input logic h, input logic e);
    valid_i = v; dst_i = d; ticket_i = t; head_i = h; end_i = e;
  endtask

  task automatic push(input logic [4:0] d, input logic [4:0] t, input logic h, input logic e);
    exp_t x;
    x.dst = d; x.tk = t; x.h = h; x.e = e;
    q.push_back(x);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    wr_ready_i = 1'b1;
    while ((q.size() != 0 || inflight_o != 3'd0) && k < 40) begin
      step();
      k++;
    end
    check(name, 32'(q.size()), 32'd0);
  endtask

  // Monitor: every WR handshake is matched against the oldest expected uop.
  always @(negedge clk) begin
    exp_t e;
    if (rdc_done_o) rdc_cnt++;
    if (rst_n && wr_valid_o && wr_ready_i) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wr_unexpected: got dst %0d, expected no uop", wr_addr_o);
      end else begin
        e = q.pop_front();
        check("wr_addr", wr_addr_o, e.dst);
        check("wr_ticket", wr_ticket_o, e.tk);
        check("wr_head", wr_head_o, e.h);
        check("wr_end", wr_end_o, e.e);
        check("rdc_done", rdc_done_o, e.e);
      end
    end
  end

  initial begin
    int base;
    rst_n = 1'b0; flush_i = 1'b0; wr_ready_i = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);

    @(negedge clk);
    check("rst_wr_valid", wr_valid_o, 1'b0);
    check("rst_inflight", inflight_o, 3'd0);
    check("rst_stage_en", stage_en_o, 4'h0);
    check("rst_stage_vld", stage_vld_o, 4'h0);
    check("rst_ready", ready_o, 1'b1);
    check("rst_idle", vex_idle_o, 1'b1);
    check("rst_rdc", rdc_done_o, 1'b0);
    check("rst_tap_b_en", frw_b_en_o, 1'b0);
    step();
    rst_n = 1'b1;

    // Stream of 6 back-to-back uops
    wr_ready_i = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      int acc, hs;
      if (c < 6) drive(1'b1, 5'(c + 1), 5'(c + 10), 1'b0, 1'b0);
      else       drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
      @(negedge clk);
      if (c < 6) begin
        check("stream_ready", ready_o, 1'b1);
        push(5'(c + 1), 5'(c + 10), 1'b0, 1'b0);
      end
      acc = (c < 6) ? c : 6;
      hs  = (c <= 4) ? 0 : ((c - 4 < 6) ? c - 4 : 6);
      check("stream_inflight", inflight_o, 32'(acc - hs));
      if (c >= 4 && c <= 9) begin
        check("stream_wr_valid", wr_valid_o, 1'b1);
        check("stream_wr_addr", wr_addr_o, 32'(c - 3));
      end
      if (c == 10) check("stream_idle", vex_idle_o, 1'b1);
      step();
    end

    // Backpressure: pipe fills, then release
    wr_ready_i = 1'b0;
    for (int c = 0; c <= 4; c++) begin
      drive(1'b1, 5'(21 + c), 5'(c), 1'b0, 1'b0);
      @(negedge clk);
      if (c < 4) begin
        check("bp_ready", ready_o, 1'b1);
        push(5'(21 + c), 5'(c), 1'b0, 1'b0);
      end else begin
        check("bp_full_ready", ready_o, 1'b0);
        check("bp_full_inflight", inflight_o, 3'd4);
        check("bp_full_stage_en", stage_en_o, 4'h0);
        check("bp_full_stage_vld", stage_vld_o, 4'hf);
      end
      step();
    end
    wr_ready_i = 1'b1;
    @(negedge clk);
    check("bp_release_ready", ready_o, 1'b1);
    check("bp_release_stage_en", stage_en_o, 4'hf);
    push(5'd25, 5'd4, 1'b0, 1'b0);
    step();
    drain("bp_drain");

    // Bubble collapse with WR stalled
    wr_ready_i = 1'b0;
    for (int c = 0; c <= 6; c++) begin
      if (c == 0)      drive(1'b1, 5'd3, 5'd1, 1'b0, 1'b0);
      else if (c == 3) drive(1'b1, 5'd4, 5'd2, 1'b0, 1'b0);
      else             drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
      @(negedge clk);
      if (c == 0) push(5'd3, 5'd1, 1'b0, 1'b0);
      if (c == 3) push(5'd4, 5'd2, 1'b0, 1'b0);
      if (c == 6) begin
        check("bubble_stage_vld", stage_vld_o, 4'b1100);
        check("bubble_inflight", inflight_o, 3'd2);
      end
      step();
    end
    drain("bubble_drain");

    // Flush with three in flight and a uop presented
    wr_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 5'(30 + c), 5'(c), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 5'd31, 5'd9, 1'b0, 1'b0);
    flush_i = 1'b1;
    @(negedge clk);
    check("flush_ready", ready_o, 1'b0);
    check("flush_stage_en", stage_en_o, 4'h0);
    step();
    flush_i = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("flush_stage_vld", stage_vld_o, 4'h0);
    check("flush_inflight", inflight_o, 3'd0);
    check("flush_wr_valid", wr_valid_o, 1'b0);
    step();

    // Forwarding taps: A at stage 1, B at stage 3
    wr_ready_i = 1'b1;
    drive(1'b1, 5'd9, 5'd7, 1'b0, 1'b0);
    @(negedge clk);
    push(5'd9, 5'd7, 1'b0, 1'b0);
    check("tap_a_en", frw_a_en_o, 1'b1);
    check("tap_a_ticket", frw_a_ticket_o, 5'd7);
    check("tap_a_addr", frw_a_addr_o, 5'd9);
    check("tap_b_en_t0", frw_b_en_o, 1'b0);
    step();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("tap_a_en_t1", frw_a_en_o, 1'b0);
    check("tap_b_en_t1", frw_b_en_o, 1'b0);
    step();
    @(negedge clk);
    check("tap_b_en", frw_b_en_o, 1'b1);
    check("tap_b_ticket", frw_b_ticket_o, 5'd7);
    check("tap_b_addr", frw_b_addr_o, 5'd9);
    step();
    drain("tap_drain");

    // Reduction done on a 3-uop instruction
    base = rdc_cnt;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 5'(11 + c), 5'(20 + c), c == 0, c == 2);
      @(negedge clk);
      push(5'(11 + c), 5'(20 + c), c == 0, c == 2);
      step();
    end
    drain("rdc_drain");
    check("rdc_pulses", 32'(rdc_cnt - base), 32'd1);

    // Asynchronous reset mid-operation
    drive(1'b1, 5'd17, 5'd3, 1'b0, 1'b0);
    step();
    step();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("async_rst_vld", stage_vld_o, 4'h0);
    check("async_rst_inflight", inflight_o, 3'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
